// File: rtl/cut_bist_tester.sv
// cut_bist_tester: LFSR pattern source and MISR response compactor for a combinational CUT,
// with a run length counter and a golden-signature compare.
module cut_bist_tester #(
   parameter int          IN_W      = 32,
   parameter int          OUT_W     = 7,
   parameter int          PATTERNS  = 1024,
   parameter logic [31:0] SEED      = 32'h0000_0001,
   parameter logic [31:0] LFSR_POLY = 32'h8020_0003,
   parameter logic [15:0] GOLDEN    = 16'h0000,
   localparam int         CW        = $clog2(PATTERNS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [IN_W-1:0]  pi_vec,
   input  logic [OUT_W-1:0] po_vec,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      signature,
   output logic [CW-1:0]    count
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
   state_t      state;
   logic [31:0] lfsr;
   logic [15:0] misr;
   logic [31:0] lfsr_nxt;
   logic [15:0] misr_nxt;
   assign lfsr_nxt  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'd0);
   assign misr_nxt  = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ 16'(po_vec);
   assign pi_vec    = lfsr[IN_W-1:0];
   assign signature = misr;
   assign pass      = misr == GOLDEN;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lfsr  <= SEED_EFF;
         misr  <= '0;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state <= RUN;
               lfsr  <= SEED_EFF;
               misr  <= '0;
               count <= '0;
               busy  <= 1'b1;
               done  <= 1'b0;
            end
            RUN: begin
               lfsr  <= lfsr_nxt;
               misr  <= misr_nxt;
               count <= (count == CW'(PATTERNS)) ? count : count + CW'(1);
               // the vector absorbed this cycle is the last one
               if (count == CW'(PATTERNS - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end
endmodule
